// File: rtl/lap_record_ctrl.sv
// Lap RAM sequencer for the stopwatch: records laps, replays them on the display and clears the RAM.
// Sole owner of the single-port RAM pins; arbitrates key strobes by fixed priority.
module lap_record_ctrl #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DW     = 24,
  parameter int RD_LAT = 1
) (
  input  logic          clk_50Mhz,
  input  logic          rst_n,
  input  logic          rec_req,
  input  logic          recall_req,
  input  logic          next_req,
  input  logic          clear_req,
  input  logic [DW-1:0] watch_data,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic          disp_sel,
  output logic [DW-1:0] disp_data,
  output logic [AW:0]   rec_count,
  output logic [AW-1:0] rec_idx,
  output logic          full,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0]    state_reg;
  logic [2:0]    ret_state_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_idx_reg;
  logic [AW-1:0] clr_ptr_reg;
  logic [AW:0]   rec_count_reg;
  logic [DW-1:0] lat_data_reg;
  logic [1:0]    rd_cnt_reg;
  logic [DW-1:0] disp_data_reg;
  logic          disp_sel_reg;

  logic          full_int;
  logic [AW:0]   rd_inc;

  assign full_int = (rec_count_reg == (AW+1)'(DEPTH));
  assign rd_inc   = {1'b0, rd_idx_reg} + (AW+1)'(1);

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      ret_state_reg <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_idx_reg    <= '0;
      clr_ptr_reg   <= '0;
      rec_count_reg <= '0;
      lat_data_reg  <= '0;
      rd_cnt_reg    <= '0;
      disp_data_reg <= '0;
      disp_sel_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_SHOW: begin
          // Only the highest-priority strobe is considered, even if it cannot act.
          if (clear_req) begin
            clr_ptr_reg  <= '0;
            disp_sel_reg <= 1'b0;
            state_reg    <= S_CLEAR;
          end else if (rec_req) begin
            if (!full_int) begin
              lat_data_reg  <= watch_data;
              ret_state_reg <= state_reg;
              state_reg     <= S_WRITE;
            end
          end else if (recall_req) begin
            if (state_reg == S_SHOW) begin
              disp_sel_reg <= 1'b0;
              state_reg    <= S_IDLE;
            end else if (rec_count_reg != '0) begin
              rd_idx_reg <= '0;
              rd_cnt_reg <= '0;
              state_reg  <= S_READ;
            end
          end else if (next_req && state_reg == S_SHOW) begin
            rd_idx_reg <= (rd_inc == rec_count_reg) ? '0 : rd_inc[AW-1:0];
            rd_cnt_reg <= '0;
            state_reg  <= S_READ;
          end
        end
        S_WRITE: begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (!full_int) begin
            rec_count_reg <= rec_count_reg + (AW+1)'(1);
          end
          state_reg <= ret_state_reg;
        end
        S_READ: begin
          // Address is held RD_LAT+1 cycles so q reflects rd_idx on the last one.
          if (rd_cnt_reg == 2'(RD_LAT)) begin
            disp_data_reg <= ram_q;
            disp_sel_reg  <= 1'b1;
            state_reg     <= S_SHOW;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 2'd1;
          end
        end
        S_CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + AW'(1);
          if (clr_ptr_reg == AW'(DEPTH-1)) begin
            rec_count_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_idx_reg    <= '0;
            clr_ptr_reg   <= '0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr = rd_idx_reg;
    ram_data = '0;
    ram_wren = 1'b0;
    if (state_reg == S_WRITE) begin
      ram_addr = wr_ptr_reg;
      ram_data = lat_data_reg;
      ram_wren = 1'b1;
    end else if (state_reg == S_CLEAR) begin
      ram_addr = clr_ptr_reg;
      ram_wren = 1'b1;
    end
  end

  assign busy      = (state_reg == S_WRITE) || (state_reg == S_READ) || (state_reg == S_CLEAR);
  assign disp_sel  = disp_sel_reg;
  assign disp_data = disp_data_reg;
  assign rec_count = rec_count_reg;
  assign rec_idx   = rd_idx_reg;
  assign full      = full_int;

endmodule
